// File: rtl/tetris_pkg.sv
// Shared playfield geometry, cell sentinel and lock-FSM state encoding
// for the per-player board logic.
package tetris_pkg;
  localparam int ROWS        = 24;
  localparam int COLS        = 10;
  localparam int HIDDEN_ROWS = 2;
  localparam int CELL_W      = 8;
  localparam int BOARD_W     = ROWS * COLS;

  localparam logic [CELL_W-1:0] CELL_INVALID = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MERGE = 3'd1,
    SCAN  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/board_row_shift.sv
// Combinational row collapse: removes row r (rows above drop by one, row 0
// zero-fills) and reports fullness of row r and of the row just above it.
module board_row_shift
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [4:0]         r,
  output logic [BOARD_W-1:0] shifted,
  output logic               row_full,
  output logic               above_full
);
  logic [ROWS-1:0] full;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    localparam logic [4:0] RI = 5'(i);
    assign full[i] = &board[i*COLS +: COLS];
    if (i == 0) begin : g_top
      assign shifted[0 +: COLS] = '0;
    end else begin : g_mid
      assign shifted[i*COLS +: COLS] = (r >= RI) ? board[(i-1)*COLS +: COLS]
                                                 : board[i*COLS +: COLS];
    end
  end

  assign row_full   = (r < 5'(ROWS)) ? full[r] : 1'b0;
  // Post-shift row r holds pre-shift row r-1.
  assign above_full = (r != 5'd0 && r < 5'(ROWS)) ? full[r - 5'd1] : 1'b0;
endmodule

// File: rtl/board_merge_clear.sv
// Per-player playfield: merges a landed piece, collapses full rows bottom-up,
// and tracks cleared-line counts and sticky game-over.
module board_merge_clear
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_board,
  input  logic               lock_valid,
  output logic               lock_ready,
  input  logic [CELL_W-1:0]  cell_0,
  input  logic [CELL_W-1:0]  cell_1,
  input  logic [CELL_W-1:0]  cell_2,
  input  logic [CELL_W-1:0]  cell_3,
  output logic [BOARD_W-1:0] board,
  output logic               busy,
  output logic               done,
  output logic [2:0]         lines_cleared,
  output logic [15:0]        total_lines,
  output logic               game_over
);
  state_e                   state;
  logic [3:0][CELL_W-1:0]   cells;
  logic [4:0]               r;
  logic [2:0]               acc;
  logic                     over_flag;
  logic [BOARD_W-1:0]       merged, shifted;
  logic                     merge_over, row_full, above_full;
  logic [16:0]              total_sum;

  assign lock_ready = (state == IDLE) && !game_over;
  assign busy       = (state != IDLE);
  assign total_sum  = {1'b0, total_lines} + 17'(acc);

  always_comb begin
    merged     = board;
    merge_over = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (cells[k] < CELL_W'(BOARD_W)) begin
        merged[cells[k]] = 1'b1;
        if (cells[k] < CELL_W'(HIDDEN_ROWS * COLS)) merge_over = 1'b1;
      end
    end
  end

  board_row_shift u_shift (
    .board      (board),
    .r          (r),
    .shifted    (shifted),
    .row_full   (row_full),
    .above_full (above_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      board         <= '0;
      cells         <= '0;
      r             <= '0;
      acc           <= '0;
      over_flag     <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
      game_over     <= 1'b0;
    end else if (clear_board) begin
      state         <= IDLE;
      board         <= '0;
      cells         <= '0;
      r             <= '0;
      acc           <= '0;
      over_flag     <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
      game_over     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (lock_valid && lock_ready) begin
          cells <= {cell_3, cell_2, cell_1, cell_0};
          state <= MERGE;
        end
        MERGE: begin
          board     <= merged;
          over_flag <= merge_over;
          acc       <= '0;
          r         <= 5'(ROWS - 1);
          state     <= SCAN;
        end
        SCAN: begin
          if (row_full)        state <= SHIFT;
          else if (r == 5'd0)  state <= DONE;
          else                 r     <= r - 5'd1;
        end
        // Stacked full rows stay here; a non-full drop-in row counts as
        // already scanned, so each clear costs exactly one extra cycle.
        SHIFT: begin
          board <= shifted;
          acc   <= acc + 3'd1;
          if (!above_full) begin
            if (r == 5'd0) state <= DONE;
            else begin
              r     <= r - 5'd1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          done          <= 1'b1;
          lines_cleared <= acc;
          total_lines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
          game_over     <= game_over | over_flag;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_merge_clear.sv
// Bench for board_merge_clear: table of lock vectors with a scoreboard of
// expected results, plus hand sequences for game-over, clear and reset.
module tb_board_merge_clear;
  import tetris_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear_board = 1'b0;
  logic               lock_valid = 1'b0;
  logic               lock_ready;
  logic [CELL_W-1:0]  cell_0 = '0, cell_1 = '0, cell_2 = '0, cell_3 = '0;
  logic [BOARD_W-1:0] board;
  logic               busy, done, game_over;
  logic [2:0]         lines_cleared;
  logic [15:0]        total_lines;

  board_merge_clear dut (
    .clk(clk), .rst_n(rst_n), .clear_board(clear_board),
    .lock_valid(lock_valid), .lock_ready(lock_ready),
    .cell_0(cell_0), .cell_1(cell_1), .cell_2(cell_2), .cell_3(cell_3),
    .board(board), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .total_lines(total_lines),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               fresh;
    int                 c0, c1, c2, c3;
    int                 lines;
    int                 lat;
    logic               has_b;
    logic [BOARD_W-1:0] eb;
    int                 etot;
  } vec_t;

  typedef struct {
    int                 lines;
    int                 lat;
    logic [BOARD_W-1:0] brd;
    int                 total;
    logic               go;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [BOARD_W-1:0] m_board = '0;
  int                 m_total = 0;
  logic               m_go    = 1'b0;

  task automatic check(input string nm, input logic [BOARD_W-1:0] act,
                       input logic [BOARD_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BOARD_W-1:0] bits4(input int a, b, c, d);
    logic [BOARD_W-1:0] v;
    v = '0;
    if (a < BOARD_W) v[a] = 1'b1;
    if (b < BOARD_W) v[b] = 1'b1;
    if (c < BOARD_W) v[c] = 1'b1;
    if (d < BOARD_W) v[d] = 1'b1;
    return v;
  endfunction

  // Reference: merge, then compact surviving rows toward the bottom.
  function automatic void model_lock(input int a, b, c, d);
    int                 cs[4];
    logic [BOARD_W-1:0] nb;
    int                 dst, lines;
    cs = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      if (cs[k] < BOARD_W) m_board[cs[k]] = 1'b1;
      if (cs[k] < HIDDEN_ROWS * COLS) m_go = 1'b1;
    end
    nb = '0; dst = ROWS - 1; lines = 0;
    for (int s = ROWS - 1; s >= 0; s--) begin
      if (&m_board[s*COLS +: COLS]) lines++;
      else begin
        nb[dst*COLS +: COLS] = m_board[s*COLS +: COLS];
        dst--;
      end
    end
    m_board = nb;
    m_total = (m_total + lines > 65535) ? 65535 : m_total + lines;
  endfunction

  function automatic void model_reset();
    m_board = '0; m_total = 0; m_go = 1'b0;
  endfunction

  function automatic void add(input logic f, input int a, b, c, d,
                              input int ln, lat, input logic hb,
                              input logic [BOARD_W-1:0] eb, input int etot);
    vec_t v;
    v.fresh = f; v.c0 = a; v.c1 = b; v.c2 = c; v.c3 = d;
    v.lines = ln; v.lat = lat; v.has_b = hb; v.eb = eb; v.etot = etot;
    vecs.push_back(v);
  endfunction

  task automatic pulse_clear();
    @(negedge clk); clear_board = 1'b1;
    @(negedge clk); clear_board = 1'b0;
    model_reset();
  endtask

  task automatic do_lock(input int a, b, c, d, input int ln, lat);
    int   w, n;
    exp_t e, got;
    w = 0;
    @(negedge clk);
    while (!lock_ready && w < 60) begin @(negedge clk); w++; end
    check("lock_ready_wait", BOARD_W'(lock_ready), BOARD_W'(1));
    if (!lock_ready) return;
    cell_0 = CELL_W'(a); cell_1 = CELL_W'(b);
    cell_2 = CELL_W'(c); cell_3 = CELL_W'(d);
    lock_valid = 1'b1;
    model_lock(a, b, c, d);
    e = '{ln, lat, m_board, m_total, m_go};
    sb.push_back(e);
    @(posedge clk); #1 lock_valid = 1'b0;
    check("ready_drop", BOARD_W'(lock_ready), BOARD_W'(0));
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!done && n < 100);
    got = sb.pop_front();
    check("done_latency", BOARD_W'(n), BOARD_W'(got.lat));
    check("lines_cleared", BOARD_W'(lines_cleared), BOARD_W'(got.lines));
    check("board", board, got.brd);
    check("total_lines", BOARD_W'(total_lines), BOARD_W'(got.total));
    check("game_over", BOARD_W'(game_over), BOARD_W'(got.go));
    check("busy_at_done", BOARD_W'(busy), BOARD_W'(0));
    @(posedge clk); #1;
    check("done_one_cycle", BOARD_W'(done), BOARD_W'(0));
  endtask

  initial begin
    // Test 1 / 2 / 3 / 6 vectors
    add(1, 230, 231, 232, 233, 0, 26, 1, bits4(230, 231, 232, 233), 0);
    add(1, 230, 231, 232, 233, 0, 26, 0, '0, -1);
    add(0, 234, 235, 236, 237, 0, 26, 0, '0, -1);
    add(0, 238, 239, 228, 229, 1, 27, 1, bits4(238, 239, 255, 255), 1);
    for (int c = 0; c < 9; c++)
      add(c == 0, 200 + c, 210 + c, 220 + c, 230 + c, 0, 26, 0, '0, -1);
    add(0, 209, 219, 229, 239, 4, 30, 1, '0, 4);
    add(1, 250, 255, 230, 230, 0, 26, 1, bits4(230, 255, 255, 255), 0);

    #12;
    check("rst_board", board, '0);
    check("rst_busy", BOARD_W'(busy), BOARD_W'(0));
    check("rst_done", BOARD_W'(done), BOARD_W'(0));
    check("rst_lines", BOARD_W'(lines_cleared), BOARD_W'(0));
    check("rst_total", BOARD_W'(total_lines), BOARD_W'(0));
    check("rst_game_over", BOARD_W'(game_over), BOARD_W'(0));
    check("rst_lock_ready", BOARD_W'(lock_ready), BOARD_W'(1));
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].fresh) pulse_clear();
      do_lock(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3,
              vecs[i].lines, vecs[i].lat);
      if (vecs[i].has_b) check("board_const", board, vecs[i].eb);
      if (vecs[i].etot >= 0)
        check("total_const", BOARD_W'(total_lines), BOARD_W'(vecs[i].etot));
    end

    // Game over: hidden-row cell freezes the board until clear_board
    pulse_clear();
    do_lock(15, 16, 17, 18, 0, 26);
    check("go_set", BOARD_W'(game_over), BOARD_W'(1));
    check("go_not_ready", BOARD_W'(lock_ready), BOARD_W'(0));
    @(negedge clk);
    cell_0 = 8'd100; cell_1 = 8'd101; cell_2 = 8'd102; cell_3 = 8'd103;
    lock_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("go_busy", BOARD_W'(busy), BOARD_W'(0));
    lock_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("go_frozen", board, bits4(15, 16, 17, 18));
    pulse_clear();
    check("clr_board", board, '0);
    check("clr_game_over", BOARD_W'(game_over), BOARD_W'(0));
    check("clr_ready", BOARD_W'(lock_ready), BOARD_W'(1));

    // clear_board landing on the SHIFT edge aborts the lock silently
    do_lock(230, 231, 232, 233, 0, 26);
    do_lock(234, 235, 236, 237, 0, 26);
    @(negedge clk);
    cell_0 = 8'd238; cell_1 = 8'd239; cell_2 = 8'd228; cell_3 = 8'd229;
    lock_valid = 1'b1;
    @(posedge clk); #1 lock_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_abort_merged", BOARD_W'(board[239:228]), BOARD_W'(12'hFFF));
    @(negedge clk); clear_board = 1'b1;
    @(posedge clk); #1;
    check("abort_board", board, '0);
    check("abort_done", BOARD_W'(done), BOARD_W'(0));
    check("abort_busy", BOARD_W'(busy), BOARD_W'(0));
    @(negedge clk); clear_board = 1'b0;
    model_reset();
    begin
      int seen;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (done) seen++; end
      check("abort_no_done", BOARD_W'(seen), BOARD_W'(0));
    end

    // Async reset mid-SCAN after a nonzero total
    do_lock(230, 231, 232, 233, 0, 26);
    do_lock(234, 235, 236, 237, 0, 26);
    do_lock(238, 239, 228, 229, 1, 27);
    @(negedge clk);
    cell_0 = 8'd200; cell_1 = 8'd201; cell_2 = 8'd202; cell_3 = 8'd203;
    lock_valid = 1'b1;
    @(posedge clk); #1 lock_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_board", board, '0);
    check("arst_busy", BOARD_W'(busy), BOARD_W'(0));
    check("arst_total", BOARD_W'(total_lines), BOARD_W'(0));
    check("arst_lines", BOARD_W'(lines_cleared), BOARD_W'(0));
    check("arst_ready", BOARD_W'(lock_ready), BOARD_W'(1));
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    do_lock(230, 231, 232, 233, 0, 26);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
